// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_pkg                                                |
// | Purpose  : Shared UART types, parity codes and timing helpers      |
// |            used by both the transmitter and the receiver.          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package uart_pkg;

  // Parity mode codes carried on the EN_PARITY parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 10;
  localparam int PARITY_ODD  = 11;

  // Line-side frame phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clocks per line bit, truncated toward zero
  function automatic int calc_bit_cycles(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Width of a counter that must hold 0..bit_cycles-1
  function automatic int calc_cnt_width(input int bit_cycles);
    return (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_baud_gen                                           |
// | Purpose  : Bit-period counter; flags the last clock of each bit.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W      = calc_cnt_width(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

  generate
    if (BIT_CYCLES < 2) begin : g_bad_baud
      $error("uart_baud_gen: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = enable_i && (cnt_q == LAST_CNT);

  // Count within a bit, wrapping exactly at the bit boundary
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_tx                                                 |
// | Purpose  : UART transmitter, 8 data bits LSB-first, optional       |
// |            parity, one stop bit, ready/valid byte handshake.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int EN_PARITY  = PARITY_ODD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_uart_tx,
  output logic       o_tx_done
);

  generate
    if ((EN_PARITY != PARITY_NONE) && (EN_PARITY != PARITY_EVEN) &&
        (EN_PARITY != PARITY_ODD)) begin : g_bad_parity
      $error("uart_tx: EN_PARITY must be 0, 10 or 11");
    end
  endgenerate

  uart_state_e state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        parity_bit;

  // Bit timer restarts on every phase change so each phase is a full bit
  uart_baud_gen #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_d != state_q),
    .enable_i (state_q != ST_IDLE),
    .bit_end_o(bit_end)
  );

  // Parity always comes from the latched byte, never from live input
  assign parity_bit = (EN_PARITY == PARITY_EVEN) ? (^data_q) : (~^data_q);

  assign o_ready   = (state_q == ST_IDLE);
  assign o_uart_tx = tx_q;
  assign o_tx_done = done_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection, one transition per completed bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_data_valid) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && (bit_cnt_q == 3'd7))
                   state_d = (EN_PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and line value for the upcoming cycle, keyed on the next state
  always_comb begin
    data_d    = data_q;
    bit_cnt_d = '0;
    done_d    = (state_q == ST_STOP) && bit_end;
    if ((state_q == ST_IDLE) && i_data_valid) begin
      data_d = i_data;
    end
    if (state_q == ST_DATA) begin
      bit_cnt_d = bit_end ? bit_cnt_q + 3'd1 : bit_cnt_q;
    end
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_cnt_d];
      ST_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_uart_tx                                              |
// | Purpose  : Directed self-checking bench for uart_tx (odd, none and |
// |            even parity instances, scoreboarded line frames).       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CF  = 1000;
  localparam int BR  = 100;
  localparam int BIT = CF / BR;

  typedef struct {
    int          k;
    logic [10:0] bits;
    int          n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] valid = 3'b000;
  logic [2:0] tx, rdy, done;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [10:0] got;

  always #5 clk = ~clk;

  uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .EN_PARITY(11)) u_odd (
    .clk(clk), .rst_n(rst_n), .i_data(data), .i_data_valid(valid[0]),
    .o_ready(rdy[0]), .o_uart_tx(tx[0]), .o_tx_done(done[0]));
  uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .EN_PARITY(0)) u_none (
    .clk(clk), .rst_n(rst_n), .i_data(data), .i_data_valid(valid[1]),
    .o_ready(rdy[1]), .o_uart_tx(tx[1]), .o_tx_done(done[1]));
  uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .EN_PARITY(10)) u_even (
    .clk(clk), .rst_n(rst_n), .i_data(data), .i_data_valid(valid[2]),
    .o_ready(rdy[2]), .o_uart_tx(tx[2]), .o_tx_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line frame: index 0 is the start bit
  function automatic exp_t model(input int k, input logic [7:0] d);
    exp_t e;
    int   ones = 0;
    int   mode;
    mode   = (k == 0) ? 11 : (k == 1) ? 0 : 10;
    e.k    = k;
    e.bits = '0;
    for (int i = 0; i < 8; i++) begin
      e.bits[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (mode == 0) begin
      e.bits[9] = 1'b1;
      e.n = 10;
    end else begin
      e.bits[9]  = (mode == 11) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      e.bits[10] = 1'b1;
      e.n = 11;
    end
    return e;
  endfunction

  // Present a byte for one cycle; returns on the first start-bit cycle
  task automatic send(input int k, input logic [7:0] d);
    @(negedge clk);
    chk("ready_before_send", 32'(rdy[k]), 32'd1);
    data     = d;
    valid[k] = 1'b1;
    sb.push_back(model(k, d));
    @(negedge clk);
    valid[k] = 1'b0;
    chk("ready_drops_after_accept", 32'(rdy[k]), 32'd0);
    chk("start_bit_first_cycle", 32'(tx[k]), 32'd0);
  endtask

  // Sample a whole frame from the current cycle, compare against the scoreboard
  task automatic capture_check(input int k, output logic [10:0] bits);
    exp_t e;
    logic stable = 1'b1;
    logic v;
    bits = '0;
    chk("scoreboard_not_empty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("scoreboard_instance", 32'(e.k), 32'(k));
    for (int i = 0; i < e.n; i++) begin
      for (int j = 0; j < BIT; j++) begin
        if (!(i == 0 && j == 0)) @(negedge clk);
        v = tx[k];
        if (j == 0) bits[i] = v;
        else if (v !== bits[i]) stable = 1'b0;
        if (done[k] !== 1'b0) stable = 1'b0;
      end
    end
    chk("frame_bits", 32'(bits), 32'(e.bits));
    chk("bit_held_full_period", 32'(stable), 32'd1);
    @(negedge clk);
    chk("tx_done_at_frame_end", 32'(done[k]), 32'd1);
    chk("ready_at_frame_end", 32'(rdy[k]), 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_tx_idle", 32'(tx), 32'h7);
    chk("reset_ready", 32'(rdy), 32'h7);
    chk("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 and 0x0E with odd parity
    send(0, 8'hA5);
    capture_check(0, got);
    chk("a5_parity_bit", 32'(got[9]), 32'd1);
    @(negedge clk);
    chk("done_single_cycle", 32'(done[0]), 32'd0);
    send(0, 8'h0E);
    capture_check(0, got);
    chk("0e_parity_bit", 32'(got[9]), 32'd0);

    // 0x07 without parity and with even parity
    send(1, 8'h07);
    capture_check(1, got);
    send(2, 8'h07);
    capture_check(2, got);
    chk("even_parity_bit", 32'(got[9]), 32'd1);

    // Back-to-back with valid held high
    @(negedge clk);
    data     = 8'h55;
    valid[0] = 1'b1;
    sb.push_back(model(0, 8'h55));
    @(negedge clk);
    chk("b2b_first_start", 32'(tx[0]), 32'd0);
    data = 8'hAA;
    sb.push_back(model(0, 8'hAA));
    capture_check(0, got);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("b2b_gap_one_clock", 32'(tx[0]), 32'd0);
    chk("b2b_ready_low", 32'(rdy[0]), 32'd0);
    capture_check(0, got);

    // Busy ignore: 0xFF pulsed mid-frame of 0x3C
    send(0, 8'h3C);
    fork
      capture_check(0, got);
      begin
        repeat (30) @(negedge clk);
        data     = 8'hFF;
        valid[0] = 1'b1;
        chk("busy_ready_low", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        valid[0] = 1'b0;
        chk("busy_ready_still_low", 32'(rdy[0]), 32'd0);
      end
    join
    repeat (3) begin
      @(negedge clk);
      chk("busy_byte_dropped_line", 32'(tx[0]), 32'd1);
      chk("busy_byte_dropped_done", 32'(done[0]), 32'd0);
    end

    // Reset during data bit 3 of 0x30 (bit 3 is 0 on the line)
    send(0, 8'h30);
    void'(sb.pop_back());
    repeat (44) @(negedge clk);
    chk("before_reset_bit3_low", 32'(tx[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_line_high", 32'(tx[0]), 32'd1);
    chk("async_reset_ready", 32'(rdy[0]), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done[0]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (BIT * 2) begin
      @(negedge clk);
      chk("after_reset_quiet", 32'({done[0], tx[0]}), 32'h1);
    end
    send(0, 8'h81);
    capture_check(0, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx
`default_nettype wire
